lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles spent in REQ plus WAIT before an access is aborted.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port arst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port mem_r_ena_i, input, 1: load request from execute.
REQ-005 SHALL have port mem_w_ena_i, input, 1: store request from execute.
REQ-006 SHALL have port mem_r_addr_i, input, 32: load byte address.
REQ-007 SHALL have port mem_w_addr_i, input, 32: store byte address.
REQ-008 SHALL have port mem_w_data_i, input, 32: store data, right-aligned.
REQ-009 SHALL have port inst_i, input, 32: instruction; bits [14:12] select the access size.
REQ-010 SHALL have ports reg_w_ena_i (1), reg_w_addr_i (5) and reg_w_data_i (32), inputs: writeback request from execute.
REQ-011 SHALL have ports reg_w_ena_o (1), reg_w_addr_o (5) and reg_w_data_o (32), outputs: registered writeback to wb.
REQ-012 SHALL have ports bus_req_o (1), bus_we_o (1), bus_addr_o (32, bits [1:0]=0), bus_be_o (4) and bus_wdata_o (32), outputs: data-bus request.
REQ-013 SHALL have ports bus_gnt_i (1), bus_rvalid_i (1) and bus_rdata_i (32), inputs: data-bus grant and response.
REQ-014 SHALL have port hold_o, output, 1: stall request to ctrl, combinational.
REQ-015 SHALL have port err_o, output, 1: one-cycle pulse flagging a misaligned, illegal or timed-out access.

Function
REQ-016 SHALL implement FSM states IDLE, REQ and WAIT.
REQ-017 In IDLE with no access requested, SHALL register reg_w_*_i onto reg_w_*_o at the next edge (latency 1) and hold hold_o at 0.
REQ-018 In IDLE with an access requested:
- SHALL assert hold_o in the same cycle.
- SHALL latch address, data, funct3 and reg_w_addr_i, then move to REQ.
- SHALL drive reg_w_ena_o to 0 at that edge.
REQ-019 When mem_w_ena_i and mem_r_ena_i are both 1, SHALL perform the store and ignore the load.
REQ-020 In REQ, SHALL drive bus_req_o=1 with stable addr, be, we and wdata; on bus_gnt_i=1, SHALL move to WAIT.
REQ-021 In WAIT, SHALL drive bus_req_o=0; on bus_rvalid_i=1, SHALL complete the access, register the result and move to IDLE.
REQ-022 SHALL compute hold_o = (IDLE & access requested & aligned & legal) | REQ | (WAIT & !bus_rvalid_i).
REQ-023 SHALL ignore bus_rvalid_i outside WAIT.
REQ-024 Byte enables SHALL be:
- byte access (funct3 x00): one-hot on addr[1:0].
- half access (x01): 4'b0011 or 4'b1100 by addr[1].
- word access (010): 4'b1111.
REQ-025 Store data SHALL be replicated into all lanes: byte as {4{d[7:0]}}, half as {2{d[15:0]}}.
REQ-026 Load data SHALL be extracted from bus_rdata_i at the addressed lane:
- LB/LH sign-extend; LBU/LHU zero-extend.
- Result goes to reg_w_data_o with reg_w_ena_o = latched reg_w_ena_i.
REQ-027 On store completion, SHALL drive reg_w_ena_o=0.
REQ-028 A misaligned access SHALL issue no bus request, pulse err_o at the next edge, drive reg_w_ena_o=0 and leave hold_o at 0. Misaligned means:
- half access with addr[0]=1;
- word access with addr[1:0]!=0.
REQ-029 Illegal funct3 SHALL be treated as misaligned:
- loads: 011, 110, 111;
- stores: any value above 010.
REQ-030 A saturating counter SHALL count cycles spent in REQ plus WAIT; on reaching TIMEOUT it SHALL:
- return to IDLE;
- pulse err_o;
- drive reg_w_ena_o=0;
- deassert hold_o in that cycle.
REQ-031 While in REQ or WAIT, SHALL drive reg_w_ena_o=0 at every edge.

Reset
REQ-032 While arst=1, SHALL force state to IDLE, clear the counter and zero all registered outputs, immediately and regardless of clk.
REQ-033 Reset mid-transaction SHALL drop bus_req_o within the same cycle and discard the pending access; no writeback occurs.
REQ-034 After arst falls, SHALL accept a request in the first clk cycle.

Verification
REQ-035 Non-memory pass-through: reg_w_ena_i=1, addr 5, data 0x1234 -> next cycle reg_w_*_o = 1/5/0x1234, hold_o=0 throughout.
REQ-036 LB with addr 0x103 and bus_rdata 0x80xxxxxx, gnt in the first REQ cycle, rvalid one cycle later:
- hold_o high for 3 cycles;
- bus_be_o=4'b1000;
- reg_w_data_o=0xFFFFFF80;
- LBU on the same data gives 0x00000080.
REQ-037 SH with addr 0x202 and data 0xABCD:
- bus_addr_o=0x200, bus_be_o=4'b1100, bus_wdata_o=0xABCDABCD, bus_we_o=1;
- reg_w_ena_o stays 0.
REQ-038 LW with addr 0x101: no bus_req_o, err_o pulses once, hold_o=0.
REQ-039 Slow bus with TIMEOUT=4 and gnt never asserted: at the 4th cycle, err_o pulses and the FSM returns to IDLE; a later request completes normally.
REQ-040 arst asserted while in WAIT: bus_req_o=0 and reg_w_ena_o=0 immediately; a late rvalid is ignored.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns execute-stage load/store requests into single
// data-bus transactions (request, grant, response), aligns store data and
// byte enables to the addressed lanes, extracts and extends load data, and
// forwards non-memory writebacks straight through to the wb stage.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        mem_r_ena_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_r_addr_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic [31:0] inst_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic [31:0] reg_w_data_i,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        hold_o,
  output logic        err_o
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CntW-1:0] r_cnt;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_regEna;

  logic        w_access;
  logic        w_isStore;
  logic [31:0] w_addr;
  logic [2:0]  w_funct3;
  logic        w_legal;
  logic        w_aligned;
  logic        w_accessOk;
  logic        w_cntLast;
  logic        w_launch;
  logic        w_reject;
  logic        w_timeout;
  logic        w_complete;
  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;
  logic [31:0] w_loadData;
  logic        w_unused;

  // Only the funct3 field of the instruction matters to this unit.
  assign w_unused = &{1'b0, inst_i[31:15], inst_i[11:0]};

  // A store takes precedence over a load when execute raises both.
  assign w_access  = mem_r_ena_i | mem_w_ena_i;
  assign w_isStore = mem_w_ena_i;
  assign w_addr    = w_isStore ? mem_w_addr_i : mem_r_addr_i;
  assign w_funct3  = inst_i[14:12];
  assign w_accessOk = w_legal & w_aligned;
  assign w_cntLast  = (r_cnt == CntLast);

  // Classify the incoming access: legal funct3 for its direction, and
  // naturally aligned for its size. Illegal encodings fail like misalignment.
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    if (w_isStore) begin
      w_legal = (w_funct3 <= 3'b010);
    end else begin
      case (w_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                 w_legal = 1'b0;
      endcase
    end
    case (w_funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~w_addr[0];
      2'b10:   w_aligned = (w_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, bus request and stall. A response arriving on the last
  // allowed cycle still completes; otherwise the timeout aborts the access
  // and releases the stall in that same cycle.
  always_comb begin
    w_next     = r_state;
    hold_o     = 1'b0;
    bus_req_o  = 1'b0;
    w_launch   = 1'b0;
    w_reject   = 1'b0;
    w_timeout  = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_accessOk) begin
            hold_o   = 1'b1;
            w_launch = 1'b1;
            w_next   = REQ;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      REQ: begin
        bus_req_o = 1'b1;
        if (w_cntLast) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end else begin
          hold_o = 1'b1;
          if (bus_gnt_i) begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid_i) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end else if (w_cntLast) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end else begin
          hold_o = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Busy-cycle counter: zero while idle and on the edge leaving REQ/WAIT,
  // otherwise counts up and saturates.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE || w_next == IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt != CntMax) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Capture the access on launch and produce the registered writeback and
  // error pulse. Writeback is suppressed except for pass-through in idle and
  // for a completed load.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_regEna     <= 1'b0;
      reg_w_ena_o  <= 1'b0;
      reg_w_addr_o <= '0;
      reg_w_data_o <= '0;
      err_o        <= 1'b0;
    end else begin
      err_o       <= w_reject | w_timeout;
      reg_w_ena_o <= 1'b0;
      if (w_launch) begin
        r_we     <= w_isStore;
        r_addr   <= w_addr;
        r_wdata  <= mem_w_data_i;
        r_funct3 <= w_funct3;
        r_rd     <= reg_w_addr_i;
        r_regEna <= reg_w_ena_i;
      end
      if (r_state == IDLE && !w_access) begin
        reg_w_ena_o  <= reg_w_ena_i;
        reg_w_addr_o <= reg_w_addr_i;
        reg_w_data_o <= reg_w_data_i;
      end else if (w_complete && !r_we) begin
        reg_w_ena_o  <= r_regEna;
        reg_w_addr_o <= r_rd;
        reg_w_data_o <= w_loadData;
      end
    end
  end

  // Bus-side view of the captured access: word address, lane enables and
  // store data replicated into every lane so the memory can pick its lane.
  always_comb begin
    bus_we_o    = r_we;
    bus_addr_o  = {r_addr[31:2], 2'b00};
    bus_be_o    = 4'b1111;
    bus_wdata_o = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        case (r_addr[1:0])
          2'b00:   bus_be_o = 4'b0001;
          2'b01:   bus_be_o = 4'b0010;
          2'b10:   bus_be_o = 4'b0100;
          default: bus_be_o = 4'b1000;
        endcase
        bus_wdata_o = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        bus_be_o    = r_addr[1] ? 4'b1100 : 4'b0011;
        bus_wdata_o = {2{r_wdata[15:0]}};
      end
      default: begin
        bus_be_o    = 4'b1111;
        bus_wdata_o = r_wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the response word and extend it to 32
  // bits, signed for LB/LH and unsigned for LBU/LHU.
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_loadByte = bus_rdata_i[7:0];
      2'b01:   w_loadByte = bus_rdata_i[15:8];
      2'b10:   w_loadByte = bus_rdata_i[23:16];
      default: w_loadByte = bus_rdata_i[31:24];
    endcase
    w_loadHalf = r_addr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
      3'b100:  w_loadData = {24'h000000, w_loadByte};
      3'b001:  w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
      3'b101:  w_loadData = {16'h0000, w_loadHalf};
      default: w_loadData = bus_rdata_i;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: a table of directed accesses, a batch of random
// accesses checked against a behavioural model, and hand-written reset
// sequences for transactions interrupted mid-flight.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic        mem_r_ena_i, mem_w_ena_i;
  logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i, inst_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        hold_o, err_o;

  int nChecks = 0;
  int nFails  = 0;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .arst(arst),
    .mem_r_ena_i(mem_r_ena_i), .mem_w_ena_i(mem_w_ena_i),
    .mem_r_addr_i(mem_r_addr_i), .mem_w_addr_i(mem_w_addr_i),
    .mem_w_data_i(mem_w_data_i), .inst_i(inst_i),
    .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i),
    .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .hold_o(hold_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // gntAt: busy cycle (1-based) in which grant is given.
  // rvAt: cycles after grant at which the response arrives.
  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rEna;
    logic [31:0] rdata;
    int          gntAt;
    int          rvAt;
    logic        expOk;
    logic [31:0] expBusAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRes;
    logic        expErr;
  } vec_t;

  vec_t tbl[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic ld, input logic st, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3,
                                 input logic [31:0] rdata, input int gntAt, input int rvAt,
                                 input logic expOk, input logic [31:0] busAddr,
                                 input logic [3:0] be, input logic [31:0] wd,
                                 input logic [31:0] res, input logic expErr);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.rd = 5'd10; v.rEna = 1'b1; v.rdata = rdata;
    v.gntAt = gntAt; v.rvAt = rvAt;
    v.expOk = expOk; v.expBusAddr = busAddr; v.expBe = be; v.expWdata = wd;
    v.expRes = res; v.expErr = expErr;
    return v;
  endfunction

  // Reference model: derives every expectation from the access rules with
  // plain arithmetic on sizes and byte offsets.
  function automatic vec_t makeRandom();
    vec_t v;
    int kind, nb, lane;
    logic legal, aligned, done;
    logic [31:0] shifted, val;
    kind    = $urandom_range(0, 2);
    v.ld    = (kind != 1);
    v.st    = (kind != 0);
    v.f3    = 3'($urandom_range(0, 7));
    v.addr  = $urandom;
    v.wdata = $urandom;
    v.rd    = 5'($urandom_range(0, 31));
    v.rEna  = 1'($urandom_range(0, 1));
    v.rdata = $urandom;
    v.gntAt = $urandom_range(1, 5);
    v.rvAt  = $urandom_range(1, 4);
    legal   = v.st ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb      = 1 << int'(v.f3[1:0]);
    lane    = int'(v.addr[1:0]);
    aligned = ((lane % nb) == 0);
    v.expOk = legal && aligned;
    v.expBusAddr = v.addr & 32'hFFFF_FFFC;
    v.expBe = 4'(((1 << nb) - 1) << lane);
    if (nb == 1)      v.expWdata = (v.wdata & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) v.expWdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
    else              v.expWdata = v.wdata;
    shifted = v.rdata >> (8 * lane);
    if (nb == 1) begin
      val = shifted & 32'hFF;
      if (!v.f3[2] && val[7]) val = val | 32'hFFFF_FF00;
    end else if (nb == 2) begin
      val = shifted & 32'hFFFF;
      if (!v.f3[2] && val[15]) val = val | 32'hFFFF_0000;
    end else begin
      val = v.rdata;
    end
    v.expRes = val;
    done     = (v.gntAt < TO) && (v.gntAt + v.rvAt <= TO);
    v.expErr = !v.expOk || !done;
    return v;
  endfunction

  // Issue one access, play the bus side cycle by cycle and check the result.
  task automatic applyStimulus(input vec_t v, input string tag);
    int endC;
    logic done;
    logic [31:0] inst;
    inst = $urandom;
    inst[14:12] = v.f3;
    mem_r_ena_i  = v.ld;
    mem_w_ena_i  = v.st;
    mem_r_addr_i = v.st ? v.addr + 32'h40 : v.addr;
    mem_w_addr_i = v.st ? v.addr : $urandom;
    mem_w_data_i = v.wdata;
    inst_i       = inst;
    reg_w_ena_i  = v.rEna;
    reg_w_addr_i = v.rd;
    reg_w_data_i = $urandom;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    checkBit({tag, " hold@issue"}, hold_o, v.expOk);
    checkBit({tag, " req@issue"}, bus_req_o, 1'b0);
    @(posedge clk); #1;
    mem_r_ena_i = 1'b0;
    mem_w_ena_i = 1'b0;
    reg_w_ena_i = 1'b0;
    if (!v.expOk) begin
      checkBit({tag, " err"}, err_o, 1'b1);
      checkBit({tag, " wbEna"}, reg_w_ena_o, 1'b0);
      checkBit({tag, " req"}, bus_req_o, 1'b0);
      checkBit({tag, " hold"}, hold_o, 1'b0);
    end else begin
      done = (v.gntAt < TO) && (v.gntAt + v.rvAt <= TO);
      endC = done ? v.gntAt + v.rvAt : TO;
      for (int c = 1; c <= endC; c++) begin
        bus_gnt_i = (c == v.gntAt);
        if (c == v.gntAt + v.rvAt) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = v.rdata;
        end else begin
          bus_rvalid_i = (c <= v.gntAt) ? 1'($urandom_range(0, 1)) : 1'b0;
          bus_rdata_i  = $urandom;
        end
        @(negedge clk);
        checkBit({tag, " busReq"}, bus_req_o, (c <= v.gntAt));
        checkBit({tag, " hold"}, hold_o, (c < endC));
        if (c == 1) begin
          checkOutput({tag, " busAddr"}, bus_addr_o, v.expBusAddr);
          checkOutput({tag, " busBe"}, {28'h0, bus_be_o}, {28'h0, v.expBe});
          checkBit({tag, " busWe"}, bus_we_o, v.st);
          if (v.st) checkOutput({tag, " busWdata"}, bus_wdata_o, v.expWdata);
        end
        @(posedge clk); #1;
        if (c < endC) checkBit({tag, " wbEnaBusy"}, reg_w_ena_o, 1'b0);
      end
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      checkBit({tag, " err"}, err_o, v.expErr);
      if (v.expErr || v.st) begin
        checkBit({tag, " wbEna"}, reg_w_ena_o, 1'b0);
      end else begin
        checkBit({tag, " wbEna"}, reg_w_ena_o, v.rEna);
        checkOutput({tag, " wbAddr"}, {27'h0, reg_w_addr_o}, {27'h0, v.rd});
        checkOutput({tag, " wbData"}, reg_w_data_o, v.expRes);
      end
    end
  endtask

  // One idle cycle with a non-memory writeback, which must pass straight through.
  task automatic applyIdle(input logic ena, input logic [4:0] a, input logic [31:0] d, input string tag);
    mem_r_ena_i  = 1'b0;
    mem_w_ena_i  = 1'b0;
    reg_w_ena_i  = ena;
    reg_w_addr_i = a;
    reg_w_data_i = d;
    @(negedge clk);
    checkBit({tag, " hold"}, hold_o, 1'b0);
    checkBit({tag, " req"}, bus_req_o, 1'b0);
    @(posedge clk); #1;
    checkBit({tag, " wbEna"}, reg_w_ena_o, ena);
    checkOutput({tag, " wbAddr"}, {27'h0, reg_w_addr_o}, {27'h0, a});
    checkOutput({tag, " wbData"}, reg_w_data_o, d);
    checkBit({tag, " errLow"}, err_o, 1'b0);
    reg_w_ena_i = 1'b0;
  endtask

  // Start a word load at 0x40 and step into REQ.
  task automatic startLoad();
    inst_i       = 32'h0000_2003;
    mem_r_ena_i  = 1'b1;
    mem_r_addr_i = 32'h40;
    reg_w_ena_i  = 1'b1;
    reg_w_addr_i = 5'd3;
    @(posedge clk); #1;
    mem_r_ena_i = 1'b0;
    reg_w_ena_i = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    mem_r_ena_i = 1'b0; mem_w_ena_i = 1'b0;
    mem_r_addr_i = '0; mem_w_addr_i = '0; mem_w_data_i = '0; inst_i = '0;
    reg_w_ena_i = 1'b0; reg_w_addr_i = '0; reg_w_data_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;

    //            ld    st    addr          wdata         f3    rdata         g  r  ok    busAddr       be       wdata         result        err
    tbl[0]  = mkVec(1'b1, 1'b0, 32'h103,      32'h0,        3'd0, 32'h8012_3456, 1, 2, 1'b1, 32'h100,      4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    tbl[1]  = mkVec(1'b1, 1'b0, 32'h103,      32'h0,        3'd4, 32'h8012_3456, 1, 2, 1'b1, 32'h100,      4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    tbl[2]  = mkVec(1'b0, 1'b1, 32'h202,      32'h0000_ABCD, 3'd1, 32'h0,       2, 1, 1'b1, 32'h200,      4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0);
    tbl[3]  = mkVec(1'b1, 1'b0, 32'h101,      32'h0,        3'd2, 32'h0,        1, 1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);
    tbl[4]  = mkVec(1'b1, 1'b0, 32'h102,      32'h0,        3'd1, 32'hF00D_1234, 1, 1, 1'b1, 32'h100,      4'b1100, 32'h0,        32'hFFFF_F00D, 1'b0);
    tbl[5]  = mkVec(1'b1, 1'b0, 32'h100,      32'h0,        3'd5, 32'hF00D_1234, 3, 1, 1'b1, 32'h100,      4'b0011, 32'h0,        32'h0000_1234, 1'b0);
    tbl[6]  = mkVec(1'b1, 1'b1, 32'h300,      32'hDEAD_BEEF, 3'd2, 32'h0,       1, 1, 1'b1, 32'h300,      4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0);
    tbl[7]  = mkVec(1'b1, 1'b0, 32'h0,        32'h0,        3'd3, 32'h0,        1, 1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);
    tbl[8]  = mkVec(1'b0, 1'b1, 32'h0,        32'h0,        3'd4, 32'h0,        1, 1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);
    tbl[9]  = mkVec(1'b1, 1'b0, 32'h10,       32'h0,        3'd2, 32'h0,        9, 1, 1'b1, 32'h10,       4'b1111, 32'h0,        32'h0,         1'b1);
    tbl[10] = mkVec(1'b1, 1'b0, 32'h20,       32'h0,        3'd2, 32'h1122_3344, 1, 1, 1'b1, 32'h20,       4'b1111, 32'h0,        32'h1122_3344, 1'b0);
    tbl[11] = mkVec(1'b1, 1'b0, 32'h24,       32'h0,        3'd2, 32'h0,        1, 5, 1'b1, 32'h24,       4'b1111, 32'h0,        32'h0,         1'b1);
    tbl[12] = mkVec(1'b0, 1'b1, 32'h1,        32'h0000_005A, 3'd0, 32'h0,       1, 1, 1'b1, 32'h0,        4'b0010, 32'h5A5A_5A5A, 32'h0,         1'b0);
    tbl[13] = mkVec(1'b1, 1'b0, 32'h3,        32'h0,        3'd1, 32'h0,        1, 1, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,         1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkBit("reset hold", hold_o, 1'b0);
    checkBit("reset busReq", bus_req_o, 1'b0);
    checkBit("reset wbEna", reg_w_ena_o, 1'b0);
    checkOutput("reset wbAddr", {27'h0, reg_w_addr_o}, 32'h0);
    checkOutput("reset wbData", reg_w_data_o, 32'h0);
    checkBit("reset err", err_o, 1'b0);
    @(posedge clk); #1;
    arst = 1'b0;

    // The first entry is issued in the very first cycle after reset release.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i], $sformatf("tbl%0d", i));
      applyIdle(1'b1, 5'(i + 1), $urandom, $sformatf("tbl%0d idle", i));
    end

    applyIdle(1'b1, 5'd5, 32'h1234, "passThrough");

    for (int i = 0; i < 80; i++) begin
      applyStimulus(makeRandom(), $sformatf("rnd%0d", i));
      applyIdle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                $sformatf("rnd%0d idle", i));
    end

    // Reset while requesting: the bus request must drop without waiting for a clock.
    startLoad();
    @(negedge clk);
    checkBit("rstReq busReq before", bus_req_o, 1'b1);
    #1 arst = 1'b1;
    #1;
    checkBit("rstReq busReq", bus_req_o, 1'b0);
    checkBit("rstReq hold", hold_o, 1'b0);
    checkBit("rstReq wbEna", reg_w_ena_o, 1'b0);
    @(posedge clk); #1;
    arst = 1'b0;
    applyIdle(1'b1, 5'd4, 32'h55, "rstReq after");

    // Reset while waiting for the response; a late response must be ignored.
    startLoad();
    bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    @(negedge clk);
    checkBit("rstWait busReq", bus_req_o, 1'b0);
    checkBit("rstWait hold before", hold_o, 1'b1);
    #1 arst = 1'b1;
    #1;
    checkBit("rstWait hold", hold_o, 1'b0);
    checkBit("rstWait wbEna", reg_w_ena_o, 1'b0);
    checkBit("rstWait busReq after", bus_req_o, 1'b0);
    @(posedge clk); #1;
    arst = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h7777_7777;
    applyIdle(1'b0, 5'd6, 32'h99, "rstWait lateRvalid");
    bus_rvalid_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
